exec_hazard_ctrl: RTL and testbench

EXEC_HAZARD_CTRL -- requirements
Module: exec_hazard_ctrl

---
 rtl/exec_ctrl_pkg.sv | 73 +++++++
 rtl/exec_ctrl_sat_counter.sv | 38 +++
 rtl/exec_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_exec_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execute-stage hazard controller: opcode
// constants, FSM state encoding, control bundle and decode helpers.
package exec_ctrl_pkg;

    localparam int unsigned OPC_W     = 4;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned CNT_W     = 16;

    localparam logic [OPC_W-1:0] OP_NOP    = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADDI   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SHLLI  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_SHRLI  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JUMP   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JUMPL  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_JUMPG  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_JUMPE  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_JUMPNE = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_CMP    = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_LOADI  = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_MOV    = OPC_W'(15);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2
    } ctrl_state_e;

    // Pipeline control bundle driven towards fetch/decode.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_bubble;
        logic redirect_valid;
    } ctrl_bus_t;

    // Instruction reads its first source register.
    function automatic logic uses_src1(input logic [OPC_W-1:0] op);
        return (op == OP_SUB)   || (op == OP_ADD)   || (op == OP_ADDI) ||
               (op == OP_SHLLI) || (op == OP_SHRLI) || (op == OP_CMP)  ||
               (op == OP_LOAD)  || (op == OP_STORE) || (op == OP_MOV);
    endfunction

    // Instruction reads its second source register.
    function automatic logic uses_src2(input logic [OPC_W-1:0] op);
        return (op == OP_SUB) || (op == OP_ADD) ||
               (op == OP_CMP) || (op == OP_STORE);
    endfunction

    // Branch resolution against the architectural flags.
    function automatic logic branch_taken(input logic [OPC_W-1:0] op,
                                          input logic z,
                                          input logic g,
                                          input logic l);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_JUMP:   taken = 1'b1;
            OP_JUMPL:  taken = l;
            OP_JUMPG:  taken = g;
            OP_JUMPE:  taken = z;
            OP_JUMPNE: taken = ~z;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/exec_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over inc).
// Ports: clk, rst_n (async active-low), inc, clr, count.
module exec_ctrl_sat_counter
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Execute-stage hazard controller: resolves branches against registered
// compare flags, detects load-use hazards, and drives Mealy stall/flush/
// redirect controls for the front end, plus stall/flush event counters.
// Inputs : clk, rst_n, id_opcode, id_src1_idx, id_src2_idx, ex_opcode,
//          ex_dest_idx, ex_target, ex_zf/gf/lf, clr_counts.
// Outputs: pc_stall, if_id_stall, if_id_flush, id_ex_bubble, redirect_valid,
//          redirect_pc, flag_z/g/l, stall_count, flush_count.
module exec_hazard_ctrl
    import exec_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPC_W-1:0]     id_opcode,
    input  logic [REG_IDX_W-1:0] id_src1_idx,
    input  logic [REG_IDX_W-1:0] id_src2_idx,
    input  logic [OPC_W-1:0]     ex_opcode,
    input  logic [REG_IDX_W-1:0] ex_dest_idx,
    input  logic [ADDR_W-1:0]    ex_target,
    input  logic                 ex_zf,
    input  logic                 ex_gf,
    input  logic                 ex_lf,
    input  logic                 clr_counts,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 redirect_valid,
    output logic [ADDR_W-1:0]    redirect_pc,
    output logic                 flag_z,
    output logic                 flag_g,
    output logic                 flag_l,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic flag_z_q, flag_g_q, flag_l_q;
    logic flag_z_d, flag_g_d, flag_l_d;

    ctrl_bus_t   ctrl_c;
    ctrl_bus_t   ctrl_gated_c;
    logic [ADDR_W-1:0] redirect_pc_c;

    logic br_taken_c;
    logic load_use_c;

    // Hazard classification of the EX/ID instruction pair.
    always_comb begin
        br_taken_c = branch_taken(ex_opcode, flag_z_q, flag_g_q, flag_l_q);
        load_use_c = (ex_opcode == OP_LOAD) && (ex_dest_idx != '0) &&
                     ((uses_src1(id_opcode) && (id_src1_idx == ex_dest_idx)) ||
                      (uses_src2(id_opcode) && (id_src2_idx == ex_dest_idx)));
    end

    // Next-state and Mealy control outputs.
    always_comb begin
        state_d       = state_q;
        ctrl_c        = '0;
        redirect_pc_c = '0;
        case (state_q)
            ST_RUN: begin
                if (br_taken_c) begin
                    ctrl_c.redirect_valid = 1'b1;
                    ctrl_c.if_id_flush    = 1'b1;
                    ctrl_c.id_ex_bubble   = 1'b1;
                    redirect_pc_c         = ex_target;
                    state_d               = ST_BR_FLUSH;
                end else if (load_use_c) begin
                    ctrl_c.pc_stall     = 1'b1;
                    ctrl_c.if_id_stall  = 1'b1;
                    ctrl_c.id_ex_bubble = 1'b1;
                    state_d             = ST_LD_STALL;
                end
            end
            ST_LD_STALL: begin
                // EX holds the inserted bubble; forwarding covers the load.
                state_d = ST_RUN;
            end
            ST_BR_FLUSH: begin
                // Synchronous fetch already captured the wrong-path word.
                ctrl_c.if_id_flush = 1'b1;
                state_d            = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Flags follow EX only on a compare.
    always_comb begin
        flag_z_d = flag_z_q;
        flag_g_d = flag_g_q;
        flag_l_d = flag_l_q;
        if (ex_opcode == OP_CMP) begin
            flag_z_d = ex_zf;
            flag_g_d = ex_gf;
            flag_l_d = ex_lf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            flag_z_q <= 1'b0;
            flag_g_q <= 1'b0;
            flag_l_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flag_z_q <= flag_z_d;
            flag_g_q <= flag_g_d;
            flag_l_q <= flag_l_d;
        end
    end

    // Reset must silence the combinational controls immediately.
    assign ctrl_gated_c = rst_n ? ctrl_c : '0;

    assign pc_stall       = ctrl_gated_c.pc_stall;
    assign if_id_stall    = ctrl_gated_c.if_id_stall;
    assign if_id_flush    = ctrl_gated_c.if_id_flush;
    assign id_ex_bubble   = ctrl_gated_c.id_ex_bubble;
    assign redirect_valid = ctrl_gated_c.redirect_valid;
    assign redirect_pc    = rst_n ? redirect_pc_c : '0;

    assign flag_z = flag_z_q;
    assign flag_g = flag_g_q;
    assign flag_l = flag_l_q;

    exec_ctrl_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl_gated_c.pc_stall),
        .clr   (clr_counts),
        .count (stall_count)
    );

    exec_ctrl_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl_gated_c.redirect_valid),
        .clr   (clr_counts),
        .count (flush_count)
    );

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Self-checking bench for exec_hazard_ctrl: directed vector table, reset and
// saturation sequences, then randomized traffic against a behavioural model.
module tb_exec_hazard_ctrl;
    import exec_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  id_opcode;
    logic [4:0]  id_src1_idx;
    logic [4:0]  id_src2_idx;
    logic [3:0]  ex_opcode;
    logic [4:0]  ex_dest_idx;
    logic [15:0] ex_target;
    logic        ex_zf, ex_gf, ex_lf;
    logic        clr_counts;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, redirect_valid;
    logic [15:0] redirect_pc;
    logic        flag_z, flag_g, flag_l;
    logic [15:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    exec_hazard_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_opcode      (id_opcode),
        .id_src1_idx    (id_src1_idx),
        .id_src2_idx    (id_src2_idx),
        .ex_opcode      (ex_opcode),
        .ex_dest_idx    (ex_dest_idx),
        .ex_target      (ex_target),
        .ex_zf          (ex_zf),
        .ex_gf          (ex_gf),
        .ex_lf          (ex_lf),
        .clr_counts     (clr_counts),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flag_z         (flag_z),
        .flag_g         (flag_g),
        .flag_l         (flag_l),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ex_op;
        logic [4:0]  dest;
        logic [3:0]  id_op;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [15:0] tgt;
        logic [2:0]  zgl;
        logic        e_stall;
        logic        e_flush;
        logic        e_bubble;
        logic        e_redir;
        logic [15:0] e_rpc;
        logic [15:0] e_sc;
        logic [15:0] e_fc;
        logic [2:0]  e_flags;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] xop, input logic [4:0] dst, input logic [3:0] iop,
                         input logic [4:0] a, input logic [4:0] b, input logic [15:0] tgt,
                         input logic [2:0] zgl, input logic clr);
        ex_opcode   = xop;
        ex_dest_idx = dst;
        id_opcode   = iop;
        id_src1_idx = a;
        id_src2_idx = b;
        ex_target   = tgt;
        {ex_zf, ex_gf, ex_lf} = zgl;
        clr_counts  = clr;
    endtask

    task automatic chk_ctrl(input string tag, input logic st, input logic fl, input logic bu,
                            input logic rv, input logic [15:0] rpc);
        chk({tag, ".pc_stall"},       32'(pc_stall),       32'(st));
        chk({tag, ".if_id_stall"},    32'(if_id_stall),    32'(st));
        chk({tag, ".if_id_flush"},    32'(if_id_flush),    32'(fl));
        chk({tag, ".id_ex_bubble"},   32'(id_ex_bubble),   32'(bu));
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        chk({tag, ".redirect_pc"},    32'(redirect_pc),    32'(rpc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(OP_NOP, 5'd0, OP_NOP, 5'd0, 5'd0, 16'h0, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural reference: remembers only what happened last cycle.
    logic        m_prev_taken, m_prev_stall;
    logic        m_z, m_g, m_l;
    int          m_sc, m_fc;

    task automatic run_random(input int n_cycles);
        logic busy, br, taken, hazard, stall, u1, u2;
        do_reset();
        m_prev_taken = 0; m_prev_stall = 0;
        m_z = 0; m_g = 0; m_l = 0; m_sc = 0; m_fc = 0;
        for (int n = 0; n < n_cycles; n++) begin
            @(negedge clk);
            drive(($urandom_range(0, 3) == 0) ? OP_LOAD : 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  16'($urandom), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 63) == 0));
            busy = m_prev_taken || m_prev_stall;
            case (ex_opcode)
                4'd6:    br = 1'b1;
                4'd7:    br = m_l;
                4'd8:    br = m_g;
                4'd9:    br = m_z;
                4'd10:   br = !m_z;
                default: br = 1'b0;
            endcase
            u1 = id_opcode inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd11, 4'd12, 4'd14, 4'd15};
            u2 = id_opcode inside {4'd1, 4'd2, 4'd11, 4'd14};
            hazard = (ex_opcode == 4'd12) && (ex_dest_idx != 0) &&
                     ((u1 && id_src1_idx == ex_dest_idx) || (u2 && id_src2_idx == ex_dest_idx));
            taken = !busy && br;
            stall = !busy && !taken && hazard;
            #1;
            chk_ctrl("rand", stall, taken || m_prev_taken, taken || stall, taken,
                     taken ? ex_target : 16'h0);
            @(posedge clk);
            if (ex_opcode == 4'd11) begin
                m_z = ex_zf; m_g = ex_gf; m_l = ex_lf;
            end
            if (clr_counts) begin
                m_sc = 0; m_fc = 0;
            end else begin
                if (stall && m_sc < 65535) m_sc++;
                if (taken && m_fc < 65535) m_fc++;
            end
            m_prev_taken = taken;
            m_prev_stall = stall;
            #1;
            chk("rand.stall_count", 32'(stall_count), 32'(m_sc));
            chk("rand.flush_count", 32'(flush_count), 32'(m_fc));
            chk("rand.flags", 32'({flag_z, flag_g, flag_l}), 32'({m_z, m_g, m_l}));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(OP_JUMP, 5'd0, OP_NOP, 5'd0, 5'd0, 16'hBEEF, 3'b111, 1'b0);
        #2;
        // Held in reset with a taken-branch pattern on the inputs.
        chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("reset.stall_count", 32'(stall_count), 32'h0);
        chk("reset.flush_count", 32'(flush_count), 32'h0);
        chk("reset.flags", 32'({flag_z, flag_g, flag_l}), 32'h0);
        do_reset();

        //           ex_op      dst  id_op     s1  s2  tgt      zgl   st fl bu rv rpc      sc fc flags
        vecs[0]  = '{OP_CMP,    0, OP_NOP,   0, 0, 16'h0,    3'b001, 0, 0, 0, 0, 16'h0,    0, 0, 3'b001};
        vecs[1]  = '{OP_JUMPL,  0, OP_NOP,   0, 0, 16'h0010, 3'b000, 0, 1, 1, 1, 16'h0010, 0, 1, 3'b001};
        vecs[2]  = '{OP_JUMP,   0, OP_NOP,   0, 0, 16'h1234, 3'b000, 0, 1, 0, 0, 16'h0,    0, 1, 3'b001};
        vecs[3]  = '{OP_NOP,    0, OP_NOP,   0, 0, 16'h0,    3'b000, 0, 0, 0, 0, 16'h0,    0, 1, 3'b001};
        vecs[4]  = '{OP_LOAD,   3, OP_ADD,   3, 0, 16'h0,    3'b000, 1, 0, 1, 0, 16'h0,    1, 1, 3'b001};
        vecs[5]  = '{OP_LOAD,   3, OP_ADD,   3, 0, 16'h0,    3'b000, 0, 0, 0, 0, 16'h0,    1, 1, 3'b001};
        vecs[6]  = '{OP_LOAD,   0, OP_MOV,   0, 0, 16'h0,    3'b000, 0, 0, 0, 0, 16'h0,    1, 1, 3'b001};
        vecs[7]  = '{OP_LOAD,   3, OP_ADDI,  5, 3, 16'h0,    3'b000, 0, 0, 0, 0, 16'h0,    1, 1, 3'b001};
        vecs[8]  = '{OP_LOAD,   3, OP_STORE, 1, 3, 16'h0,    3'b000, 1, 0, 1, 0, 16'h0,    2, 1, 3'b001};
        vecs[9]  = '{OP_NOP,    0, OP_NOP,   0, 0, 16'h0,    3'b000, 0, 0, 0, 0, 16'h0,    2, 1, 3'b001};
        vecs[10] = '{OP_CMP,    0, OP_NOP,   0, 0, 16'h0,    3'b100, 0, 0, 0, 0, 16'h0,    2, 1, 3'b100};
        vecs[11] = '{OP_JUMPNE, 0, OP_NOP,   0, 0, 16'h0055, 3'b000, 0, 0, 0, 0, 16'h0,    2, 1, 3'b100};
        vecs[12] = '{OP_JUMPE,  0, OP_NOP,   0, 0, 16'h0042, 3'b000, 0, 1, 1, 1, 16'h0042, 2, 2, 3'b100};
        vecs[13] = '{OP_NOP,    0, OP_NOP,   0, 0, 16'h0,    3'b000, 0, 1, 0, 0, 16'h0,    2, 2, 3'b100};

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].ex_op, vecs[i].dest, vecs[i].id_op, vecs[i].s1, vecs[i].s2,
                  vecs[i].tgt, vecs[i].zgl, 1'b0);
            #1;
            chk_ctrl($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush,
                     vecs[i].e_bubble, vecs[i].e_redir, vecs[i].e_rpc);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.stall_count", i), 32'(stall_count), 32'(vecs[i].e_sc));
            chk($sformatf("vec%0d.flush_count", i), 32'(flush_count), 32'(vecs[i].e_fc));
            chk($sformatf("vec%0d.flags", i), 32'({flag_z, flag_g, flag_l}), 32'(vecs[i].e_flags));
        end

        // Reset asserted while the wrong-path fetch is being flushed.
        @(negedge clk);
        drive(OP_JUMP, 5'd0, OP_NOP, 5'd0, 5'd0, 16'h0ABC, 3'b000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(OP_NOP, 5'd0, OP_NOP, 5'd0, 5'd0, 16'h0, 3'b000, 1'b0);
        #1;
        chk("rstflush.pre_flush", 32'(if_id_flush), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstflush.flush", 32'(if_id_flush), 32'h0);
        chk("rstflush.stall_count", 32'(stall_count), 32'h0);
        chk("rstflush.flush_count", 32'(flush_count), 32'h0);
        drive(OP_JUMP, 5'd0, OP_NOP, 5'd0, 5'd0, 16'h0777, 3'b000, 1'b0);
        #1;
        chk_ctrl("rstflush.held", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(OP_NOP, 5'd0, OP_NOP, 5'd0, 5'd0, 16'h0, 3'b000, 1'b0);
        @(negedge clk);
        drive(OP_LOAD, 5'd7, OP_SUB, 5'd2, 5'd7, 16'h0, 3'b000, 1'b0);
        #1;
        chk_ctrl("rstflush.run_after", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);

        // Stall counter saturation and clear priority.
        do_reset();
        @(negedge clk);
        force dut.u_stall_cnt.cnt_q = 16'hFFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        drive(OP_LOAD, 5'd3, OP_ADD, 5'd3, 5'd0, 16'h0, 3'b000, 1'b0);
        #1;
        chk("sat.stall1", 32'(pc_stall), 32'h1);
        @(posedge clk);
        #1;
        chk("sat.count_ffff", 32'(stall_count), 32'hFFFF);
        @(negedge clk);
        drive(OP_NOP, 5'd0, OP_NOP, 5'd0, 5'd0, 16'h0, 3'b000, 1'b0);
        @(negedge clk);
        drive(OP_LOAD, 5'd3, OP_ADD, 5'd3, 5'd0, 16'h0, 3'b000, 1'b0);
        #1;
        chk("sat.stall2", 32'(pc_stall), 32'h1);
        @(posedge clk);
        #1;
        chk("sat.count_hold", 32'(stall_count), 32'hFFFF);
        @(negedge clk);
        drive(OP_NOP, 5'd0, OP_NOP, 5'd0, 5'd0, 16'h0, 3'b000, 1'b0);
        @(negedge clk);
        drive(OP_LOAD, 5'd3, OP_ADD, 5'd3, 5'd0, 16'h0, 3'b000, 1'b1);
        #1;
        chk("sat.stall3", 32'(pc_stall), 32'h1);
        @(posedge clk);
        #1;
        chk("sat.clr_stall", 32'(stall_count), 32'h0);
        chk("sat.clr_flush", 32'(flush_count), 32'h0);

        run_random(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
